// File: rtl/vga_dma_pkg.sv
// ----------------------------------------------------------------------------
// vga_dma_pkg : shared FSM state codes and default frame geometry for vga_dma
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vga_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } dma_state_e;

  localparam int WORDS_PER_LINE = 36;
  localparam int LINES          = 455;
  localparam int FB_WORDS_DEF   = WORDS_PER_LINE * LINES;

endpackage

`default_nettype wire

// File: rtl/vga_dma_addr.sv
// ----------------------------------------------------------------------------
// vga_dma_addr : loadable wrapping frame-buffer word counter
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_dma_addr #(
  parameter logic [15:0] BASE     = 16'h0000,
  parameter int          FB_WORDS = 16380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        ce_i,
  output logic [15:0] addr_o
);

  localparam logic [15:0] LAST = 16'(BASE + 16'(FB_WORDS) - 16'd1);

  logic [15:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i)
      addr_d = BASE;
    else if (ce_i)
      addr_d = (addr_q == LAST) ? BASE : addr_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_q <= BASE;
    else     addr_q <= addr_d;
  end

  assign addr_o = addr_q;

endmodule

`default_nettype wire

// File: rtl/vga_dma.sv
// ----------------------------------------------------------------------------
// vga_dma : video word fetcher between VGA controller and memory arbiter.
// Optional VGA_DMA_STATS_EN adds underrun/ucount overrun statistics. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_dma
  import vga_dma_pkg::*;
#(
  parameter logic [15:0] BASE     = 16'h0000,
  parameter int          FB_WORDS = FB_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vreq,
  input  logic        vreset,
  output logic        vack,
  output logic [15:0] pixels,
  output logic        dma_req,
  output logic [15:0] dma_addr,
  input  logic        dma_gnt,
  input  logic        dma_rdy,
  input  logic [15:0] dma_data
`ifdef VGA_DMA_STATS_EN
  ,
  output logic        underrun,
  output logic [7:0]  ucount
`endif
);

  dma_state_e  state_q, state_d;
  logic        queued_q, queued_d;
  logic        queued_rst_q, queued_rst_d;
  logic        dma_req_q;
  logic [15:0] pixels_q;
  logic        load_base;
  logic        drop;
  logic        vreset_acc;

  always_comb begin
    state_d      = state_q;
    queued_d     = queued_q;
    queued_rst_d = queued_rst_q;
    load_base    = 1'b0;
    drop         = 1'b0;
    case (state_q)
      S_IDLE: if (vreq) begin
        state_d   = S_REQ;
        load_base = vreset;
      end
      S_REQ:  if (dma_gnt) state_d = S_WAIT;
      S_WAIT: if (dma_rdy) state_d = S_DONE;
      S_DONE: if (queued_q) begin
        state_d      = S_REQ;
        load_base    = queued_rst_q;
        queued_d     = 1'b0;
        queued_rst_d = 1'b0;
      end else begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A request arriving while busy fills the single queue slot; the slot is
    // already released when DONE issues it, so that request is kept.
    if (vreq && (state_q != S_IDLE)) begin
      if (queued_d) drop = 1'b1;
      else          queued_d = 1'b1;
      queued_rst_d = queued_rst_d | vreset;
    end
    vreset_acc = vreq & vreset & ~drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      queued_q     <= 1'b0;
      queued_rst_q <= 1'b0;
      dma_req_q    <= 1'b0;
      pixels_q     <= 16'h0000;
    end else begin
      state_q      <= state_d;
      queued_q     <= queued_d;
      queued_rst_q <= queued_rst_d;
      dma_req_q    <= (state_d == S_REQ);
      if ((state_q == S_WAIT) && dma_rdy)
        pixels_q <= dma_data;
    end
  end

  vga_dma_addr #(
    .BASE     (BASE),
    .FB_WORDS (FB_WORDS)
  ) u_addr (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_base),
    .ce_i   ((state_q == S_REQ) && dma_gnt),
    .addr_o (dma_addr)
  );

  assign vack    = (state_q == S_DONE);
  assign pixels  = pixels_q;
  assign dma_req = dma_req_q;

`ifdef VGA_DMA_STATS_EN
  logic       underrun_q;
  logic [7:0] ucount_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= 1'b0;
      ucount_q   <= 8'h00;
    end else if (vreset_acc) begin
      underrun_q <= 1'b0;
      ucount_q   <= 8'h00;
    end else if (drop) begin
      underrun_q <= 1'b1;
      if (ucount_q != 8'hFF) ucount_q <= ucount_q + 8'd1;
    end
  end

  assign underrun = underrun_q;
  assign ucount   = ucount_q;
`else
  logic unused_stats;
  assign unused_stats = vreset_acc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_dma.sv
// ----------------------------------------------------------------------------
// tb_vga_dma : directed self-checking bench for vga_dma (short frame for wrap)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vga_dma;

  localparam int FBW = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vreq = 1'b0, vreset = 1'b0;
  logic        dma_gnt = 1'b0, dma_rdy = 1'b0;
  logic [15:0] dma_data = 16'h0000;
  logic        vack, dma_req;
  logic [15:0] pixels, dma_addr;
`ifdef VGA_DMA_STATS_EN
  logic        underrun;
  logic [7:0]  ucount;
`endif

  int checks = 0;
  int errors = 0;

  vga_dma #(.BASE(16'h0000), .FB_WORDS(FBW)) dut (
    .clk      (clk),
    .rst      (rst),
    .vreq     (vreq),
    .vreset   (vreset),
    .vack     (vack),
    .pixels   (pixels),
    .dma_req  (dma_req),
    .dma_addr (dma_addr),
    .dma_gnt  (dma_gnt),
    .dma_rdy  (dma_rdy),
    .dma_data (dma_data)
`ifdef VGA_DMA_STATS_EN
    ,
    .underrun (underrun),
    .ucount   (ucount)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete fetch with a plain or restarting request.
  task automatic fetch(input logic rs, input int gdly, input logic [15:0] exp_addr,
                       input logic [15:0] data);
    vreq = 1'b1; vreset = rs;
    tick();
    vreq = 1'b0; vreset = 1'b0;
    chk("fetch_req", {15'd0, dma_req}, 16'd1);
    chk("fetch_addr", dma_addr, exp_addr);
    repeat (gdly) tick();
    dma_gnt = 1'b1;
    tick();
    dma_gnt = 1'b0; dma_rdy = 1'b1; dma_data = data;
    tick();
    dma_rdy = 1'b0;
    chk("fetch_vack", {15'd0, vack}, 16'd1);
    chk("fetch_pixels", pixels, data);
    tick();
    chk("fetch_vack_end", {15'd0, vack}, 16'd0);
  endtask

  initial begin
    // 1 reset
    repeat (2) tick();
    chk("rst_vack", {15'd0, vack}, 16'd0);
    chk("rst_req", {15'd0, dma_req}, 16'd0);
    chk("rst_addr", dma_addr, 16'h0000);
    chk("rst_pixels", pixels, 16'h0000);
    rst = 1'b0;
    tick();

    // 2 restart fetch, minimum latency
    vreq = 1'b1; vreset = 1'b1;
    tick();
    vreq = 1'b0; vreset = 1'b0;
    chk("t2_req", {15'd0, dma_req}, 16'd1);
    chk("t2_addr", dma_addr, 16'h0000);
    dma_gnt = 1'b1;
    tick();
    dma_gnt = 1'b0; dma_rdy = 1'b1; dma_data = 16'hA5C3;
    chk("t2_req_drop", {15'd0, dma_req}, 16'd0);
    chk("t2_vack_early", {15'd0, vack}, 16'd0);
    tick();
    dma_rdy = 1'b0;
    chk("t2_vack", {15'd0, vack}, 16'd1);
    chk("t2_pixels", pixels, 16'hA5C3);
    tick();
    chk("t2_vack_one", {15'd0, vack}, 16'd0);

    // 3 full (shortened) frame then wrap
    fetch(1'b1, 0, 16'h0000, 16'h1000);
    for (int i = 1; i < FBW; i++) begin
      fetch(1'b0, 0, 16'(i), 16'(16'h2000 + i));
      repeat (3) tick();
    end
    fetch(1'b0, 0, 16'h0000, 16'h3000);

    // 4 busy queue: second vreq one cycle later, grant delayed 2 cycles
    vreq = 1'b1;
    tick();
    chk("t4_addr0", dma_addr, 16'h0001);
    tick();
    vreq = 1'b0;
    tick();
    dma_gnt = 1'b1;
    tick();
    dma_gnt = 1'b0; dma_rdy = 1'b1; dma_data = 16'h1111;
    tick();
    dma_rdy = 1'b0;
    chk("t4_vack0", {15'd0, vack}, 16'd1);
    chk("t4_pix0", pixels, 16'h1111);
    tick();
    chk("t4_vack_gap", {15'd0, vack}, 16'd0);
    chk("t4_req1", {15'd0, dma_req}, 16'd1);
    chk("t4_addr1", dma_addr, 16'h0002);
    dma_gnt = 1'b1;
    tick();
    dma_gnt = 1'b0; dma_rdy = 1'b1; dma_data = 16'h2222;
    tick();
    dma_rdy = 1'b0;
    chk("t4_vack1", {15'd0, vack}, 16'd1);
    chk("t4_pix1", pixels, 16'h2222);
    tick();
    chk("t4_idle_req", {15'd0, dma_req}, 16'd0);

    // 5 overrun: three vreqs during one stalled fetch
    vreq = 1'b1;
    tick();
    chk("t5_addr0", dma_addr, 16'h0003);
    tick();
    tick();
    vreq = 1'b0;
`ifdef VGA_DMA_STATS_EN
    chk("t5_underrun", {15'd0, underrun}, 16'd1);
    chk("t5_ucount", {8'd0, ucount}, 16'd1);
`endif
    dma_gnt = 1'b1;
    tick();
    dma_gnt = 1'b0; dma_rdy = 1'b1; dma_data = 16'h3333;
    tick();
    dma_rdy = 1'b0;
    chk("t5_vack0", {15'd0, vack}, 16'd1);
    tick();
    chk("t5_addr1", dma_addr, 16'h0004);
    dma_gnt = 1'b1;
    tick();
    dma_gnt = 1'b0; dma_rdy = 1'b1; dma_data = 16'h4444;
    tick();
    dma_rdy = 1'b0;
    chk("t5_vack1", {15'd0, vack}, 16'd1);
    chk("t5_pix1", pixels, 16'h4444);
    repeat (3) tick();
    chk("t5_no_third", {15'd0, dma_req}, 16'd0);
    chk("t5_addr_end", dma_addr, 16'h0005);

    // 6 async reset in WAIT
    vreq = 1'b1;
    tick();
    vreq = 1'b0;
    chk("t6_addr", dma_addr, 16'h0005);
    dma_gnt = 1'b1;
    tick();
    dma_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_req", {15'd0, dma_req}, 16'd0);
    chk("t6_async_addr", dma_addr, 16'h0000);
    #1 rst = 1'b0;
    dma_rdy = 1'b1; dma_data = 16'hDEAD;
    tick();
    dma_rdy = 1'b0;
    chk("t6_late_vack", {15'd0, vack}, 16'd0);
    tick();
    chk("t6_late_vack2", {15'd0, vack}, 16'd0);
    chk("t6_pixels", pixels, 16'h0000);
`ifdef VGA_DMA_STATS_EN
    chk("t6_underrun_clr", {15'd0, underrun}, 16'd0);
`endif
    fetch(1'b1, 1, 16'h0000, 16'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
